// File: rtl/rsa_cmd_pkg.sv
// Shared definitions for the ARM<->FPGA RSA command responder: command codes,
// FSM state type and the LED encoding of each state.
package rsa_cmd_pkg;

  localparam int unsigned DATA_W = 1024;
  localparam int unsigned CMD_W  = 32;

  localparam logic [31:0] CMD_COMPUTE_MONT = 32'd1;
  localparam logic [31:0] CMD_READ_MOD     = 32'd2;
  localparam logic [31:0] CMD_READ_RSQ     = 32'd3;
  localparam logic [31:0] CMD_READ_EXP     = 32'd4;
  localparam logic [31:0] CMD_WRITE        = 32'd5;
  localparam logic [31:0] CMD_COMPUTE_EXP  = 32'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_START,
    ST_WAIT,
    ST_TX,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TGT_MOD,
    TGT_RSQ,
    TGT_EXP
  } rx_tgt_e;

  function automatic logic [3:0] state_leds(input state_e s);
    logic [3:0] l;
    l = 4'b0000;
    case (s)
      ST_IDLE:           l = 4'b0001;
      ST_RX:             l = 4'b0010;
      ST_START, ST_WAIT: l = 4'b0100;
      ST_TX:             l = 4'b1000;
      ST_DONE:           l = 4'b1111;
      default:           l = 4'b0000;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rsa_host_cmd_responder.sv
// Command/data responder between the ARM host glue and the Montgomery/exponentiation
// core: decodes commands, stores operands, launches the core and returns its result.
module rsa_host_cmd_responder
  import rsa_cmd_pkg::*;
#(
  parameter int unsigned DATA_W = rsa_cmd_pkg::DATA_W,
  parameter int unsigned CMD_W  = rsa_cmd_pkg::CMD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  arm_to_fpga_cmd,
  input  logic              arm_to_fpga_cmd_valid,
  output logic              fpga_to_arm_done,
  input  logic              fpga_to_arm_done_read,
  input  logic              arm_to_fpga_data_valid,
  output logic              arm_to_fpga_data_ready,
  input  logic [DATA_W-1:0] arm_to_fpga_data,
  output logic              fpga_to_arm_data_valid,
  input  logic              fpga_to_arm_data_ready,
  output logic [DATA_W-1:0] fpga_to_arm_data,
  output logic [DATA_W-1:0] mod_o,
  output logic [DATA_W-1:0] rsq_o,
  output logic [DATA_W-1:0] exp_o,
  output logic              core_start,
  output logic              core_mode,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [3:0]        leds
);

  localparam logic [CMD_W-1:0] C_MONT  = CMD_W'(CMD_COMPUTE_MONT);
  localparam logic [CMD_W-1:0] C_RMOD  = CMD_W'(CMD_READ_MOD);
  localparam logic [CMD_W-1:0] C_RRSQ  = CMD_W'(CMD_READ_RSQ);
  localparam logic [CMD_W-1:0] C_REXP  = CMD_W'(CMD_READ_EXP);
  localparam logic [CMD_W-1:0] C_WRITE = CMD_W'(CMD_WRITE);
  localparam logic [CMD_W-1:0] C_EXP   = CMD_W'(CMD_COMPUTE_EXP);

  state_e            state_q;
  rx_tgt_e           rx_tgt_q;
  logic              done_q;
  logic              data_ready_q;
  logic              data_valid_q;
  logic              core_start_q;
  logic              core_mode_q;
  logic [DATA_W-1:0] mod_q;
  logic [DATA_W-1:0] rsq_q;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] res_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rx_tgt_q     <= TGT_MOD;
      done_q       <= 1'b0;
      data_ready_q <= 1'b0;
      data_valid_q <= 1'b0;
      core_start_q <= 1'b0;
      core_mode_q  <= 1'b0;
      mod_q        <= '0;
      rsq_q        <= '0;
      exp_q        <= '0;
      res_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_to_fpga_cmd_valid) begin
            case (arm_to_fpga_cmd)
              C_RMOD: begin
                rx_tgt_q     <= TGT_MOD;
                data_ready_q <= 1'b1;
                state_q      <= ST_RX;
              end
              C_RRSQ: begin
                rx_tgt_q     <= TGT_RSQ;
                data_ready_q <= 1'b1;
                state_q      <= ST_RX;
              end
              C_REXP: begin
                rx_tgt_q     <= TGT_EXP;
                data_ready_q <= 1'b1;
                state_q      <= ST_RX;
              end
              C_MONT, C_EXP: begin
                core_mode_q  <= (arm_to_fpga_cmd == C_EXP);
                core_start_q <= 1'b1;
                state_q      <= ST_START;
              end
              C_WRITE: begin
                data_valid_q <= 1'b1;
                state_q      <= ST_TX;
              end
              default: begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            endcase
          end
        end

        ST_RX: begin
          if (arm_to_fpga_data_valid && data_ready_q) begin
            case (rx_tgt_q)
              TGT_RSQ: rsq_q <= arm_to_fpga_data;
              TGT_EXP: exp_q <= arm_to_fpga_data;
              default: mod_q <= arm_to_fpga_data;
            endcase
            data_ready_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= ST_DONE;
          end
        end

        // core_start is high exactly while in START
        ST_START: begin
          core_start_q <= 1'b0;
          state_q      <= ST_WAIT;
        end

        ST_WAIT: begin
          if (core_done) begin
            res_q   <= core_result;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_TX: begin
          if (fpga_to_arm_data_ready && data_valid_q) begin
            data_valid_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (fpga_to_arm_done_read) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          done_q       <= 1'b0;
          data_ready_q <= 1'b0;
          data_valid_q <= 1'b0;
          core_start_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    leds = state_leds(state_q);
  end

  assign fpga_to_arm_done       = done_q;
  assign arm_to_fpga_data_ready = data_ready_q;
  assign fpga_to_arm_data_valid = data_valid_q;
  assign fpga_to_arm_data       = res_q;
  assign mod_o                  = mod_q;
  assign rsq_o                  = rsq_q;
  assign exp_o                  = exp_q;
  assign core_start             = core_start_q;
  assign core_mode              = core_mode_q;

endmodule

// File: tb/tb_rsa_host_cmd_responder.sv
// Randomized self-checking bench for rsa_host_cmd_responder against a transaction-level
// model of the operand/result registers and the command handshake.
module tb_rsa_host_cmd_responder;

  localparam int unsigned DW = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   cmd;
  logic          cmd_valid;
  logic          done;
  logic          done_read;
  logic          h_valid;
  logic          h_ready;
  logic [DW-1:0] h_data;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [DW-1:0] mod_o, rsq_o, exp_o;
  logic          core_start, core_mode, core_done;
  logic [DW-1:0] core_result;
  logic [3:0]    leds;

  logic [DW-1:0] m_mod, m_rsq, m_exp, m_res;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  rsa_host_cmd_responder #(.DATA_W(DW), .CMD_W(32)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .arm_to_fpga_cmd        (cmd),
    .arm_to_fpga_cmd_valid  (cmd_valid),
    .fpga_to_arm_done       (done),
    .fpga_to_arm_done_read  (done_read),
    .arm_to_fpga_data_valid (h_valid),
    .arm_to_fpga_data_ready (h_ready),
    .arm_to_fpga_data       (h_data),
    .fpga_to_arm_data_valid (r_valid),
    .fpga_to_arm_data_ready (r_ready),
    .fpga_to_arm_data       (r_data),
    .mod_o                  (mod_o),
    .rsq_o                  (rsq_o),
    .exp_o                  (exp_o),
    .core_start             (core_start),
    .core_mode              (core_mode),
    .core_done              (core_done),
    .core_result            (core_result),
    .leds                   (leds)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int unsigned i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, " mod"}, mod_o, m_mod);
    check({tag, " rsq"}, rsq_o, m_rsq);
    check({tag, " exp"}, exp_o, m_exp);
    check({tag, " res"}, r_data, m_res);
  endtask

  task automatic finish_done();
    int unsigned n;
    check("done_set", DW'(done), DW'(1));
    check("leds_done", DW'(leds), DW'(4'b1111));
    n = $urandom_range(0, 3);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      check("done_hold", DW'(done), DW'(1));
    end
    done_read = 1'b1;
    tick();
    done_read = 1'b0;
    check("done_clr", DW'(done), DW'(0));
    check("leds_idle", DW'(leds), DW'(4'b0001));
  endtask

  task automatic do_rx(input logic [31:0] code, input logic [DW-1:0] data);
    int unsigned n;
    // data offered while idle must not be captured
    h_valid = 1'b1;
    h_data  = rand_wide();
    tick();
    h_valid = 1'b0;
    check("idle_noready", DW'(h_ready), DW'(0));
    cmd = code;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rx_ready", DW'(h_ready), DW'(1));
    check("leds_rx", DW'(leds), DW'(4'b0010));
    n = $urandom_range(0, 3);
    for (int unsigned i = 0; i < n; i++) begin
      h_data = rand_wide();
      tick();
      check("rx_wait_ready", DW'(h_ready), DW'(1));
      check("rx_wait_done", DW'(done), DW'(0));
    end
    h_data  = data;
    h_valid = 1'b1;
    tick();
    h_valid = 1'b0;
    h_data  = rand_wide();
    case (code)
      32'd2: m_mod = data;
      32'd3: m_rsq = data;
      default: m_exp = data;
    endcase
    check("rx_ready_drop", DW'(h_ready), DW'(0));
    check_regs("rx");
    finish_done();
  endtask

  task automatic do_compute(input logic [31:0] code, input logic [DW-1:0] result,
                            input int unsigned lat, input bit inject);
    cmd = code;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("start_pulse", DW'(core_start), DW'(1));
    check("start_mode", DW'(core_mode), DW'(code == 32'd6));
    check("leds_start", DW'(leds), DW'(4'b0100));
    tick();
    check("start_once", DW'(core_start), DW'(0));
    for (int unsigned i = 0; i < lat; i++) begin
      if (inject) begin
        cmd = 32'd2;
        cmd_valid = 1'b1;
        h_valid = 1'b1;
        h_data = rand_wide();
      end
      tick();
      check("wait_nostart", DW'(core_start), DW'(0));
      check("wait_nodone", DW'(done), DW'(0));
      check("wait_noready", DW'(h_ready), DW'(0));
    end
    cmd_valid = 1'b0;
    h_valid = 1'b0;
    core_result = result;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    core_result = rand_wide();
    m_res = result;
    check("cmp_mode_held", DW'(core_mode), DW'(code == 32'd6));
    check_regs("cmp");
    finish_done();
  endtask

  task automatic do_tx();
    int unsigned n;
    cmd = 32'd5;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("tx_valid", DW'(r_valid), DW'(1));
    check("tx_data", r_data, m_res);
    check("leds_tx", DW'(leds), DW'(4'b1000));
    n = $urandom_range(0, 3);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      check("tx_hold", DW'(r_valid), DW'(1));
      check("tx_nodone", DW'(done), DW'(0));
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("tx_valid_drop", DW'(r_valid), DW'(0));
    check_regs("tx");
    finish_done();
  endtask

  task automatic do_unknown(input logic [31:0] code);
    cmd = code;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("unk_noready", DW'(h_ready), DW'(0));
    check("unk_novalid", DW'(r_valid), DW'(0));
    check("unk_nostart", DW'(core_start), DW'(0));
    check_regs("unk");
    finish_done();
  endtask

  task automatic stray_core_done();
    core_result = rand_wide();
    core_done = 1'b1;
    done_read = 1'b1;
    tick();
    core_done = 1'b0;
    done_read = 1'b0;
    check("stray_res", r_data, m_res);
    check("stray_nodone", DW'(done), DW'(0));
    check("stray_leds", DW'(leds), DW'(4'b0001));
  endtask

  initial begin
    logic [31:0] unk;
    reset = 1'b1;
    cmd = '0; cmd_valid = 1'b0; done_read = 1'b0;
    h_valid = 1'b0; h_data = '0; r_ready = 1'b0;
    core_done = 1'b0; core_result = '0;
    m_mod = '0; m_rsq = '0; m_exp = '0; m_res = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_done", DW'(done), DW'(0));
    check("rst_ready", DW'(h_ready), DW'(0));
    check("rst_rvalid", DW'(r_valid), DW'(0));
    check("rst_start", DW'(core_start), DW'(0));
    check("rst_mode", DW'(core_mode), DW'(0));
    check("rst_leds", DW'(leds), DW'(4'b0001));
    check_regs("rst");

    do_tx();
    do_rx(32'd2, rand_wide());
    do_compute(32'd1, rand_wide(), 20, 1'b0);
    do_tx();
    do_compute(32'd6, rand_wide(), 5, 1'b1);
    do_unknown(32'd7);
    do_unknown(32'd0);
    stray_core_done();

    for (int unsigned it = 0; it < 40; it++) begin
      case ($urandom_range(0, 6))
        0: do_rx(32'd2, rand_wide());
        1: do_rx(32'd3, rand_wide());
        2: do_rx(32'd4, rand_wide());
        3: do_compute(($urandom_range(0, 1) == 0) ? 32'd1 : 32'd6, rand_wide(),
                      $urandom_range(0, 8), bit'($urandom_range(0, 1)));
        4: do_tx();
        5: begin
          unk = $urandom_range(7, 32'hFFFF_FFFF);
          do_unknown(unk);
        end
        default: stray_core_done();
      endcase
    end

    cmd = 32'd3;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    h_valid = 1'b1;
    h_data = rand_wide();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    h_valid = 1'b0;
    tick();
    m_mod = '0; m_rsq = '0; m_exp = '0; m_res = '0;
    check("rrst_ready", DW'(h_ready), DW'(0));
    check("rrst_done", DW'(done), DW'(0));
    check("rrst_leds", DW'(leds), DW'(4'b0001));
    check_regs("rrst");
    do_rx(32'd3, rand_wide());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
